riscv_irq_ctrl: RTL

- Multi-channel interrupt controller for the RV32I core; replaces the single unused interrupt input with NUM_IRQ prioritised, maskable sources.
- Synchronises external requests, latches edge or level events, selects the winner by fixed priority, and presents a vector address to the core through a req/ack/done handshake.
- Software configures it through a small register port driven by the core's memory unit decode.

---
 rtl/riscv_irq_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/riscv_irq_ctrl.sv
// Fixed-priority, maskable interrupt controller for the RV32I core: synchronises sources,
// captures edge/level events and hands one vector at a time to the core via req/ack/done.
module riscv_irq_ctrl #(
    parameter int unsigned        NUM_IRQ     = 8,
    parameter int unsigned        BITNESS     = 32,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = {NUM_IRQ{1'b1}},
    parameter logic [BITNESS-1:0] VEC_BASE    = BITNESS'(32'h0000_0100),
    parameter int unsigned        VEC_STRIDE  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we_i,
    input  logic [1:0]         cfg_addr_i,
    input  logic [BITNESS-1:0] cfg_wdata_i,
    output logic [BITNESS-1:0] cfg_rdata_o,
    output logic               irq_req_o,
    output logic [4:0]         irq_id_o,
    output logic [BITNESS-1:0] irq_vec_o,
    input  logic               irq_ack_i,
    input  logic               irq_done_i
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e                                state_q, state_d;
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]   sync_q;
    logic [NUM_IRQ-1:0]                    s_d_q;
    logic [NUM_IRQ-1:0]                    edge_pend_q, edge_pend_d;
    logic [NUM_IRQ-1:0]                    enable_q, enable_d;
    logic [NUM_IRQ-1:0]                    active_q, active_d;
    logic                                  global_q, global_d;
    logic [4:0]                            id_q, id_d;

    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [31:0]        elig_ext;
    logic [31:0]        id_onehot;
    logic [4:0]         winner;
    logic               unused_bits;

    assign sync_s    = sync_q[SYNC_STAGES-1];
    assign edge_set  = sync_s & ~s_d_q & EDGE_MASK;
    // Level sources are not stored: pending follows the synchronised input directly.
    assign pending   = (edge_pend_q & EDGE_MASK) | (sync_s & ~EDGE_MASK);
    assign eligible  = pending & enable_q & {NUM_IRQ{global_q}};
    assign elig_ext  = 32'(eligible);
    assign id_onehot = 32'd1 << id_q;
    assign w1c       = (cfg_we_i && cfg_addr_i == 2'd1) ? cfg_wdata_i[NUM_IRQ-1:0] : '0;
    assign unused_bits = ^{cfg_wdata_i, id_onehot};

    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner = 5'(i);
        end
    end

    always_comb begin
        enable_d = enable_q;
        global_d = global_q;
        if (cfg_we_i && cfg_addr_i == 2'd0) enable_d = cfg_wdata_i[NUM_IRQ-1:0];
        if (cfg_we_i && cfg_addr_i == 2'd3) global_d = cfg_wdata_i[0];
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        active_d = active_q;
        ack_clr  = '0;
        case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d = StReq;
                    id_d    = winner;
                end
            end
            StReq: begin
                // Ack beats a same-cycle loss of eligibility.
                if (irq_ack_i) begin
                    state_d  = StService;
                    active_d = id_onehot[NUM_IRQ-1:0];
                    ack_clr  = id_onehot[NUM_IRQ-1:0];
                end else if (!elig_ext[id_q]) begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (irq_done_i) begin
                    state_d  = StIdle;
                    active_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // New edge events win over same-cycle ack or W1C clears.
    assign edge_pend_d = ((edge_pend_q & ~(ack_clr | w1c)) | edge_set) & EDGE_MASK;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            sync_q      <= '0;
            s_d_q       <= '0;
            edge_pend_q <= '0;
            enable_q    <= '0;
            active_q    <= '0;
            global_q    <= 1'b0;
            id_q        <= '0;
        end else begin
            state_q     <= state_d;
            sync_q      <= {sync_q[SYNC_STAGES-2:0], irq_i};
            s_d_q       <= sync_s;
            edge_pend_q <= edge_pend_d;
            enable_q    <= enable_d;
            active_q    <= active_d;
            global_q    <= global_d;
            id_q        <= id_d;
        end
    end

    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            2'd0:    cfg_rdata_o[NUM_IRQ-1:0] = enable_q;
            2'd1:    cfg_rdata_o[NUM_IRQ-1:0] = pending;
            2'd2:    cfg_rdata_o[NUM_IRQ-1:0] = active_q;
            default: cfg_rdata_o[0]           = global_q;
        endcase
    end

    assign irq_req_o = (state_q == StReq);
    assign irq_id_o  = id_q;
    assign irq_vec_o = VEC_BASE + BITNESS'(id_q) * BITNESS'(VEC_STRIDE);

endmodule
